pingpong_buf_ctrl: RTL

- Parametrised ping-pong buffer: two banks of 2**ADDR_W words of DATA_W bits in one inferred dual-port RAM.
- The write side fills one bank from a valid/ready stream (typically 14-bit ADC samples) while the read side drains the other bank over a valid/ready stream.
- Banks swap automatically on full and empty, with frame-end marking, status flags and an overflow flag for sources that cannot stall.

---
 rtl/pingpong_buf_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong buffer controller: two banks in one dual-port RAM, the write side fills one
// bank from a valid/ready stream while the read side drains the other one.
module pingpong_buf_ctrl #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic [1:0]        bank_full,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic [CNT_W-1:0]  swap_cnt
);

  logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_load;
  logic              wr_end;
  logic              rd_end;
  logic [1:0]        bank_full_nxt;

  assign in_ready = ~bank_full[wr_bank];
  assign wr_acc   = in_valid & in_ready;
  assign rd_load  = bank_full[rd_bank] & (~out_valid | out_ready);
  assign wr_end   = wr_acc & (wr_ptr == '1);
  assign rd_end   = rd_load & (rd_ptr == '1);

  // A write only fills a bank that is not full and a read only frees a full one, so the
  // set and clear below can never hit the same bit.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_end) bank_full_nxt[wr_bank] = 1'b1;
    if (rd_end) bank_full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[{wr_bank, wr_ptr}] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      bank_full <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      ovf       <= 1'b0;
      swap_cnt  <= '0;
    end else begin
      bank_full <= bank_full_nxt;

      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (wr_end) begin
          wr_bank  <= ~wr_bank;
          swap_cnt <= swap_cnt + CNT_W'(1);
        end
      end

      if (rd_load) begin
        out_data  <= mem[{rd_bank, rd_ptr}];
        out_valid <= 1'b1;
        out_last  <= (rd_ptr == '1);
        rd_ptr    <= rd_ptr + ADDR_W'(1);
        if (rd_end) rd_bank <= ~rd_bank;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if (in_valid & ~in_ready) ovf <= 1'b1;
      else if (ovf_clr)         ovf <= 1'b0;
    end
  end

endmodule
